ept_block_tx_feeder: RTL and testbench

Byte-buffering source for the host-bound block transfer path. User logic pushes bytes into an internal FIFO; the feeder packages them into blocks of at most BLOCK_LEN bytes, pulses `start_transfer` with `uc_length`, and presents bytes on `transfer_to_host`, advancing once per cycle of `transfer_ready`. It sits directly upstream of the EPT active block and drives that block's `start_transfer`, `uc_length` and `transfer_to_host` inputs.

---
 rtl/ept_block_tx_feeder_if.sv | 25 ++
 rtl/ept_block_tx_feeder.sv | 155 +++++++++++++++
 tb/tb_ept_block_tx_feeder.sv | 331 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ept_block_tx_feeder_if.sv
// Byte-push / block-launch bundle between user logic, the block TX feeder and the EPT active block.
// master = the side that pushes bytes and supplies transfer_ready; slave = the feeder itself.
interface ept_block_tx_feeder_if;
  logic [7:0] wr_data;
  logic       wr_en;
  logic       flush;
  logic       transfer_ready;
  logic       start_transfer;
  logic [7:0] uc_length;
  logic [7:0] transfer_to_host;
  logic       full;
  logic [8:0] level;
  logic       busy;
  logic       overflow;

  modport master (
    output wr_data, wr_en, flush, transfer_ready,
    input  start_transfer, uc_length, transfer_to_host, full, level, busy, overflow
  );

  modport slave (
    input  wr_data, wr_en, flush, transfer_ready,
    output start_transfer, uc_length, transfer_to_host, full, level, busy, overflow
  );
endinterface

// File: rtl/ept_block_tx_feeder.sv
// Byte FIFO that cuts its contents into blocks of up to BLOCK_LEN bytes for the EPT active block.
// Optional idle auto-flush is compiled in when FEEDER_TIMEOUT_EN is defined.
module ept_block_tx_feeder #(
  parameter int DEPTH      = 256,
  parameter int BLOCK_LEN  = 64,
  parameter int GAP_CYCLES = 4,
  parameter int TIMEOUT    = 1024
) (
  input logic                 uc_clk,
  input logic                 uc_reset,
  ept_block_tx_feeder_if.slave bus
);

  localparam int         AW      = $clog2(DEPTH);
  localparam int         GW      = $clog2(GAP_CYCLES);
  localparam logic [8:0] DEPTH_L = 9'(DEPTH);
  localparam logic [8:0] BLOCK_L = 9'(BLOCK_LEN);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_START = 2'd1;
  localparam logic [1:0] S_SEND  = 2'd2;
  localparam logic [1:0] S_GAP   = 2'd3;

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [8:0]    level;
  logic          overflow;
  logic [1:0]    state;
  logic [7:0]    uc_length_q;
  logic [7:0]    sent;
  logic [GW-1:0] gap_cnt;
  logic          flush_pending;

  logic       push;
  logic       pop;
  logic       launch;
  logic [7:0] launch_len;
  logic       flush_req;

  assign push       = bus.wr_en && (level != DEPTH_L);
  assign pop        = (state == S_SEND) && bus.transfer_ready && (sent < uc_length_q);
  assign launch     = (state == S_IDLE) &&
                      ((level >= BLOCK_L) || (flush_pending && (level != 9'd0)));
  assign launch_len = (level >= BLOCK_L) ? 8'(BLOCK_LEN) : level[7:0];

`ifdef FEEDER_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);

  logic [TW-1:0] idle_cnt;
  logic          timeout_hit;

  // Counts only while a partial block sits idle; any accepted byte restarts the wait.
  always_ff @(posedge uc_clk or negedge uc_reset) begin
    if (!uc_reset) begin
      idle_cnt <= '0;
    end else if ((state != S_IDLE) || push || (level == 9'd0) || (level >= BLOCK_L)) begin
      idle_cnt <= '0;
    end else if (idle_cnt != TW'(TIMEOUT)) begin
      idle_cnt <= idle_cnt + 1'b1;
    end
  end

  assign timeout_hit = (idle_cnt == TW'(TIMEOUT));
  assign flush_req   = bus.flush || timeout_hit;
`else
  assign flush_req   = bus.flush;
`endif

  // NOTE: the storage array has no reset; only pointers and level are cleared, which is
  // enough to make old contents unreachable and lets the array map onto plain RAM.
  always_ff @(posedge uc_clk) begin
    if (push) begin
      mem[wr_ptr] <= bus.wr_data;
    end
  end

  // NOTE: every register below uses non-blocking assignment so all state updates
  // see the same pre-edge values regardless of block ordering.
  always_ff @(posedge uc_clk or negedge uc_reset) begin
    if (!uc_reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      level    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   level <= level + 9'd1;
        2'b01:   level <= level - 9'd1;
        default: level <= level;
      endcase
      if (bus.wr_en && (level == DEPTH_L)) overflow <= 1'b1;
    end
  end

  // A launch that takes every buffered byte satisfies the flush; a larger backlog keeps it pending.
  always_ff @(posedge uc_clk or negedge uc_reset) begin
    if (!uc_reset) begin
      flush_pending <= 1'b0;
    end else if (launch && ({1'b0, launch_len} == level)) begin
      flush_pending <= 1'b0;
    end else if (flush_req && (level != 9'd0)) begin
      flush_pending <= 1'b1;
    end
  end

  always_ff @(posedge uc_clk or negedge uc_reset) begin
    if (!uc_reset) begin
      state       <= S_IDLE;
      uc_length_q <= 8'd0;
      sent        <= 8'd0;
      gap_cnt     <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (launch) begin
            state       <= S_START;
            uc_length_q <= launch_len;
            sent        <= 8'd0;
          end
        end
        S_START: state <= S_SEND;
        S_SEND: begin
          // Leaving on the final pop keeps block spacing at START + pops + gap + IDLE.
          if (pop) begin
            sent <= sent + 8'd1;
            if (sent == uc_length_q - 8'd1) begin
              state   <= S_GAP;
              gap_cnt <= '0;
            end
          end
        end
        default: begin
          if (gap_cnt == GW'(GAP_CYCLES - 1)) begin
            state       <= S_IDLE;
            uc_length_q <= 8'd0;
          end else begin
            gap_cnt <= gap_cnt + 1'b1;
          end
        end
      endcase
    end
  end

  assign bus.start_transfer   = (state == S_START);
  assign bus.uc_length        = uc_length_q;
  assign bus.transfer_to_host = (level == 9'd0) ? 8'h00 : mem[rd_ptr];
  assign bus.full             = (level == DEPTH_L);
  assign bus.level            = level;
  assign bus.busy             = (state != S_IDLE);
  assign bus.overflow         = overflow;

endmodule

// File: tb/tb_ept_block_tx_feeder.sv
// Directed bench for ept_block_tx_feeder: a 256/64 instance for block framing and a 4/8 instance
// for full/overflow/wrap. Timeout expectations follow FEEDER_TIMEOUT_EN.
module tb_ept_block_tx_feeder;

  logic uc_clk;
  logic uc_reset;

  ept_block_tx_feeder_if bus_a ();
  ept_block_tx_feeder_if bus_b ();

  ept_block_tx_feeder #(.DEPTH(256), .BLOCK_LEN(64), .GAP_CYCLES(4), .TIMEOUT(16)) dut_a (
    .uc_clk   (uc_clk),
    .uc_reset (uc_reset),
    .bus      (bus_a.slave)
  );

  ept_block_tx_feeder #(.DEPTH(4), .BLOCK_LEN(8), .GAP_CYCLES(4), .TIMEOUT(16)) dut_b (
    .uc_clk   (uc_clk),
    .uc_reset (uc_reset),
    .bus      (bus_b.slave)
  );

  int tests = 0;
  int fails = 0;

  logic [7:0] rx_q [$];
  logic [7:0] len_q [$];
  bit         in_send = 1'b0;
  int         pop_cnt = 0;
  int         cur_len = 0;

  initial uc_clk = 1'b0;
  always #5 uc_clk = ~uc_clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog expired");
  end

  // Records each launch length and the bytes consumed on ready cycles of that block.
  always @(negedge uc_clk) begin
    if (!uc_reset) begin
      in_send <= 1'b0;
    end else begin
      if (in_send && bus_a.transfer_ready && (pop_cnt < cur_len)) begin
        rx_q.push_back(bus_a.transfer_to_host);
        pop_cnt <= pop_cnt + 1;
        if (pop_cnt + 1 == cur_len) in_send <= 1'b0;
      end
      if (bus_a.start_transfer) begin
        in_send <= 1'b1;
        pop_cnt <= 0;
        cur_len <= int'(bus_a.uc_length);
        len_q.push_back(bus_a.uc_length);
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge uc_clk);
    #1;
  endtask

  task automatic write_seq(input logic [7:0] first, input int n);
    for (int i = 0; i < n; i++) begin
      bus_a.wr_en   = 1'b1;
      bus_a.wr_data = first + 8'(i);
      tick();
    end
    bus_a.wr_en = 1'b0;
  endtask

  task automatic pulse_flush();
    bus_a.flush = 1'b1;
    tick();
    bus_a.flush = 1'b0;
  endtask

  task automatic wait_start(input string tag, input int budget);
    bit found = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge uc_clk);
      if (bus_a.start_transfer) begin
        found = 1'b1;
        break;
      end
    end
    check(tag, 32'(found), 32'd1);
  endtask

  task automatic wait_idle(input string tag, input int budget, output int busy_cycles);
    bit done = 1'b0;
    busy_cycles = 0;
    for (int i = 0; i < budget; i++) begin
      @(negedge uc_clk);
      if (bus_a.busy) busy_cycles++;
      else begin
        done = 1'b1;
        break;
      end
    end
    check(tag, 32'(done), 32'd1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_start"},    32'(bus_a.start_transfer),   32'd0);
    check({tag, "_len"},      32'(bus_a.uc_length),        32'd0);
    check({tag, "_data"},     32'(bus_a.transfer_to_host), 32'd0);
    check({tag, "_full"},     32'(bus_a.full),             32'd0);
    check({tag, "_level"},    32'(bus_a.level),            32'd0);
    check({tag, "_busy"},     32'(bus_a.busy),             32'd0);
    check({tag, "_overflow"}, 32'(bus_a.overflow),         32'd0);
  endtask

  initial begin
    int bc;
    int base_rx;
    int base_len;
    bit done;

    uc_reset = 1'b0;
    bus_a.wr_data = 8'h00; bus_a.wr_en = 1'b0; bus_a.flush = 1'b0; bus_a.transfer_ready = 1'b0;
    bus_b.wr_data = 8'h00; bus_b.wr_en = 1'b0; bus_b.flush = 1'b0; bus_b.transfer_ready = 1'b0;
    repeat (3) @(posedge uc_clk);
    @(negedge uc_clk);
    check_reset_outputs("rst");
    uc_reset = 1'b1;
    tick();

    // Full 64-byte block with ready held high: launch timing, byte order, busy span.
    bus_a.transfer_ready = 1'b1;
    base_rx  = rx_q.size();
    base_len = len_q.size();
    write_seq(8'h00, 64);
    @(negedge uc_clk);
    check("t1_idle_eval_start", 32'(bus_a.start_transfer), 32'd0);
    check("t1_level_64",        32'(bus_a.level),          32'd64);
    @(negedge uc_clk);
    check("t1_start_pulse", 32'(bus_a.start_transfer), 32'd1);
    check("t1_uc_length",   32'(bus_a.uc_length),      32'd64);
    wait_idle("t1_idle_reached", 200, bc);
    check("t1_busy_after_start", 32'(bc), 32'd68);
    check("t1_level_0",    32'(bus_a.level),          32'd0);
    check("t1_len_idle_0", 32'(bus_a.uc_length),      32'd0);
    check("t1_one_launch", 32'(len_q.size() - base_len), 32'd1);
    check("t1_rx_count",   32'(rx_q.size() - base_rx),   32'd64);
    for (int i = 0; i < 64; i++) check("t1_byte", 32'(rx_q[base_rx + i]), 32'(i));
    tick();

    // Partial block on flush; empty flush launches nothing; pending flag cleared after launch.
    base_rx  = rx_q.size();
    base_len = len_q.size();
    write_seq(8'hA0, 5);
    pulse_flush();
    wait_start("t2_flush_start", 10);
    check("t2_uc_length", 32'(bus_a.uc_length), 32'd5);
    wait_idle("t2_idle", 50, bc);
    check("t2_level_0", 32'(bus_a.level), 32'd0);
    for (int i = 0; i < 5; i++) check("t2_byte", 32'(rx_q[base_rx + i]), 32'(8'hA0 + i));
    tick();
    pulse_flush();
    repeat (20) @(negedge uc_clk);
    check("t2_empty_flush_no_launch", 32'(len_q.size() - base_len), 32'd1);
    tick();
    write_seq(8'hC5, 1);
    repeat (20) @(negedge uc_clk);
    check("t2_pending_cleared", 32'(len_q.size() - base_len), 32'd1);
    check("t2_level_1",         32'(bus_a.level),             32'd1);
    tick();
    base_rx = rx_q.size();
    pulse_flush();
    wait_start("t2_single_start", 10);
    check("t2_single_len", 32'(bus_a.uc_length), 32'd1);
    wait_idle("t2_single_idle", 50, bc);
    check("t2_single_byte", 32'(rx_q[base_rx]), 32'hC5);
    tick();

    // Backlog of 130 bytes with ready low, then drained as 64 + 64 leaving 2.
    bus_a.transfer_ready = 1'b0;
    base_rx  = rx_q.size();
    base_len = len_q.size();
    write_seq(8'h00, 130);
    @(negedge uc_clk);
    check("t3_level_130", 32'(bus_a.level), 32'd130);
    tick();
    bus_a.transfer_ready = 1'b1;
    done = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(negedge uc_clk);
      if ((len_q.size() - base_len >= 2) && !bus_a.busy) begin
        done = 1'b1;
        break;
      end
    end
    check("t3_two_blocks_done", 32'(done), 32'd1);
    repeat (20) @(negedge uc_clk);
    check("t3_launches", 32'(len_q.size() - base_len), 32'd2);
    check("t3_len0",     32'(len_q[base_len]),         32'd64);
    check("t3_len1",     32'(len_q[base_len + 1]),     32'd64);
    check("t3_level_2",  32'(bus_a.level),             32'd2);
    for (int i = 0; i < 128; i++) check("t3_byte", 32'(rx_q[base_rx + i]), 32'(i));
    tick();
    pulse_flush();
    wait_start("t3_tail_start", 10);
    check("t3_tail_len", 32'(bus_a.uc_length), 32'd2);
    wait_idle("t3_tail_idle", 50, bc);
    check("t3_tail_b0", 32'(rx_q[base_rx + 128]), 32'd128);
    check("t3_tail_b1", 32'(rx_q[base_rx + 129]), 32'd129);
    check("t3_tail_level", 32'(bus_a.level), 32'd0);
    tick();

    // Small FIFO: full, dropped write, sticky overflow, write+pop across pointer wrap.
    for (int i = 0; i < 4; i++) begin
      bus_b.wr_en   = 1'b1;
      bus_b.wr_data = 8'h10 + 8'(i);
      tick();
    end
    check("t4_full_after_4",  32'(bus_b.full),     32'd1);
    check("t4_level_4",       32'(bus_b.level),    32'd4);
    check("t4_no_overflow",   32'(bus_b.overflow), 32'd0);
    bus_b.wr_data = 8'h14;
    tick();
    bus_b.wr_en = 1'b0;
    check("t4_overflow_set",  32'(bus_b.overflow), 32'd1);
    check("t4_level_still_4", 32'(bus_b.level),    32'd4);
    repeat (5) tick();
    check("t4_overflow_sticky", 32'(bus_b.overflow), 32'd1);
    bus_b.flush = 1'b1;
    tick();
    bus_b.flush = 1'b0;
    done = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge uc_clk);
      if (bus_b.start_transfer) begin
        done = 1'b1;
        break;
      end
    end
    check("t4_start_seen", 32'(done),                   32'd1);
    check("t4_uc_length",  32'(bus_b.uc_length),        32'd4);
    check("t4_head_10",    32'(bus_b.transfer_to_host), 32'h10);
    tick();
    bus_b.transfer_ready = 1'b1;
    bus_b.wr_en          = 1'b1;
    bus_b.wr_data        = 8'h20;
    tick();
    check("t4_drop_on_full_pop", 32'(bus_b.level),            32'd3);
    check("t4_not_full",         32'(bus_b.full),             32'd0);
    check("t4_head_11",          32'(bus_b.transfer_to_host), 32'h11);
    bus_b.wr_data = 8'h21;
    tick();
    check("t4_level_const_a", 32'(bus_b.level),            32'd3);
    check("t4_head_12",       32'(bus_b.transfer_to_host), 32'h12);
    bus_b.wr_data = 8'h22;
    tick();
    check("t4_level_const_b", 32'(bus_b.level),            32'd3);
    check("t4_head_13",       32'(bus_b.transfer_to_host), 32'h13);
    bus_b.wr_data = 8'h23;
    tick();
    bus_b.wr_en          = 1'b0;
    bus_b.transfer_ready = 1'b0;
    check("t4_level_const_c", 32'(bus_b.level),            32'd3);
    check("t4_head_wrapped",  32'(bus_b.transfer_to_host), 32'h21);
    check("t4_gap_busy",      32'(bus_b.busy),             32'd1);
    check("t4_gap_len_held",  32'(bus_b.uc_length),        32'd4);
    check("t4_overflow_kept", 32'(bus_b.overflow),         32'd1);
    repeat (8) tick();

    // Reset in the middle of a block, then a clean block afterwards.
    bus_a.transfer_ready = 1'b0;
    write_seq(8'h40, 64);
    wait_start("t5_start", 10);
    tick();
    bus_a.transfer_ready = 1'b1;
    repeat (10) tick();
    bus_a.transfer_ready = 1'b0;
    check("t5_level_54", 32'(bus_a.level),            32'd54);
    check("t5_head_4a",  32'(bus_a.transfer_to_host), 32'h4A);
    uc_reset = 1'b0;
    #2;
    check_reset_outputs("t5_rst");
    check("t5_rst_b_overflow", 32'(bus_b.overflow), 32'd0);
    check("t5_rst_b_level",    32'(bus_b.level),    32'd0);
    @(posedge uc_clk);
    #1;
    uc_reset = 1'b1;
    tick();
    bus_a.transfer_ready = 1'b1;
    base_rx  = rx_q.size();
    base_len = len_q.size();
    write_seq(8'h80, 64);
    wait_start("t5_fresh_start", 10);
    check("t5_fresh_len", 32'(bus_a.uc_length), 32'd64);
    wait_idle("t5_fresh_idle", 200, bc);
    check("t5_fresh_count", 32'(rx_q.size() - base_rx), 32'd64);
    for (int i = 0; i < 64; i++) check("t5_fresh_byte", 32'(rx_q[base_rx + i]), 32'(8'h80 + i));
    tick();

    // Idle partial block: auto-flush only when the timeout feature is built in.
    base_len = len_q.size();
    write_seq(8'h55, 3);
`ifdef FEEDER_TIMEOUT_EN
    wait_start("t6_timeout_start", 40);
    check("t6_timeout_len", 32'(bus_a.uc_length), 32'd3);
    wait_idle("t6_timeout_idle", 50, bc);
`else
    repeat (40) @(negedge uc_clk);
    check("t6_no_auto_launch", 32'(len_q.size() - base_len), 32'd0);
    check("t6_level_held",     32'(bus_a.level),             32'd3);
    tick();
    pulse_flush();
    wait_start("t6_flush_start", 10);
    check("t6_flush_len", 32'(bus_a.uc_length), 32'd3);
    wait_idle("t6_flush_idle", 50, bc);
`endif
    check("t6_level_0", 32'(bus_a.level), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
